// File: rtl/mips_defs.sv
// Shared MIPS encodings: opcodes, functs, PC source selects and fetch FSM states.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [1:0] PCSRC_BRANCH = 2'b00;
    localparam logic [1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] PCSRC_JREG   = 2'b10;
    localparam logic [1:0] PCSRC_INC    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_ERROR  = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/instr_branch_decode.sv
// Combinational control-flow decode of one instruction word.
module instr_branch_decode
    import mips_defs::*;
(
    input  logic [31:0] instr_i,
    output logic [1:0]  pc_src_o,
    output logic        branch_ne_o,
    output logic        link_o,
    output logic [31:0] b_address_o,
    output logic [25:0] j_address_o
);

    // Branch/jump class from opcode, with funct only consulted for R-type.
    always_comb begin
        pc_src_o    = PCSRC_INC;
        branch_ne_o = 1'b0;
        link_o      = 1'b0;
        case (instr_i[31:26])
            OP_BEQ:   pc_src_o = PCSRC_BRANCH;
            OP_BNE: begin
                pc_src_o    = PCSRC_BRANCH;
                branch_ne_o = 1'b1;
            end
            OP_J:     pc_src_o = PCSRC_JUMP;
            OP_JAL: begin
                pc_src_o = PCSRC_JUMP;
                link_o   = 1'b1;
            end
            OP_RTYPE: begin
                if (instr_i[5:0] == FN_JR) begin
                    pc_src_o = PCSRC_JREG;
                end else if (instr_i[5:0] == FN_JALR) begin
                    pc_src_o = PCSRC_JREG;
                    link_o   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Target fields are produced for every word; the PC picks via pc_src.
    assign b_address_o = {{16{instr_i[15]}}, instr_i[15:0]};
    assign j_address_o = instr_i[25:0];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: issues PC to instruction memory, waits with timeout,
// captures and decodes the word, and strobes the PC to advance.
module instr_fetch_ctrl
    import mips_defs::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [1:0]  pc_src,
    output logic [31:0] b_address,
    output logic [25:0] j_address,
    output logic        branch_ne,
    output logic        link,
    output logic        pc_en,
    output logic        fetch_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_req_q, fetch_err_q;
    logic [31:0]      mem_addr_q, instr_q, b_address_q;
    logic [25:0]      j_address_q;
    logic [1:0]       pc_src_q;
    logic             branch_ne_q, link_q;

    logic [1:0]       dec_pc_src;
    logic             dec_branch_ne, dec_link;
    logic [31:0]      dec_b_address;
    logic [25:0]      dec_j_address;

    // Decode the word as it arrives so the decoded fields are already
    // registered during the DECODE cycle, together with pc_en.
    instr_branch_decode u_dec (
        .instr_i     (mem_rdata),
        .pc_src_o    (dec_pc_src),
        .branch_ne_o (dec_branch_ne),
        .link_o      (dec_link),
        .b_address_o (dec_b_address),
        .j_address_o (dec_j_address)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; ready wins over the timeout on the last wait cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_REQ;
            ST_REQ:    state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_ready)             state_d = ST_DECODE;
                else if (cnt_q == CNT_LAST) state_d = ST_ERROR;
            end
            ST_DECODE: state_d = stall ? ST_HOLD : ST_REQ;
            ST_HOLD:   if (!stall) state_d = ST_REQ;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request, capture, decode and timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            cnt_q       <= '0;
            instr_q     <= '0;
            pc_src_q    <= PCSRC_INC;
            b_address_q <= '0;
            j_address_q <= '0;
            branch_ne_q <= 1'b0;
            link_q      <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    mem_addr_q <= pc_in;
                    mem_req_q  <= 1'b1;
                    cnt_q      <= '0;
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        instr_q     <= mem_rdata;
                        mem_req_q   <= 1'b0;
                        pc_src_q    <= dec_pc_src;
                        b_address_q <= dec_b_address;
                        j_address_q <= dec_j_address;
                        branch_ne_q <= dec_branch_ne;
                        link_q      <= dec_link;
                    end else if (cnt_q == CNT_LAST) begin
                        fetch_err_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_DECODE);
    assign pc_en       = (state_q == ST_DECODE);
    assign pc_src      = pc_src_q;
    assign b_address   = b_address_q;
    assign j_address   = j_address_q;
    assign branch_ne   = branch_ne_q;
    assign link        = link_q;
    assign fetch_err   = fetch_err_q;

endmodule
